// File: rtl/riscv_pkg.sv
// Shared types and constants for the ID/EX stage: ALU opcodes, default widths
// and the packed EX-stage control bundle.
package riscv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int REGW_DEF  = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       src_a_pc;
        logic       src_b_imm;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        src_a_pc:  1'b0,
        src_b_imm: 1'b0,
        alu_ctrl:  ALU_ADD
    };

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding select: EX/MEM result beats MEM/WB value beats the
// register-file read captured in ID/EX; x0 is never forwarded.
module fwd_unit #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic [REGW-1:0]  rs,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [REGW-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] fwd_data
);

    // Priority select between the two bypass sources and the stored operand
    always_comb begin
        fwd_data = rs_data;
        if (mem_reg_write && (mem_rd != {REGW{1'b0}}) && (mem_rd == rs)) begin
            fwd_data = mem_fwd_data;
        end else if (wb_reg_write && (wb_rd != {REGW{1'b0}}) && (wb_rd == rs)) begin
            fwd_data = wb_data;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold/flush control
// and forwarded operand selection for the ALU.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REGW  = REGW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [REGW-1:0]  id_rs1,
    input  logic [REGW-1:0]  id_rs2,
    input  logic [REGW-1:0]  id_rd,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_src_a_pc,
    input  logic             id_src_b_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [REGW-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic [WIDTH-1:0] wb_data,
    output logic             load_use_stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [WIDTH-1:0] ex_pc,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write
);

    logic             valid_q,    valid_d;
    ex_ctrl_t         ctrl_q,     ctrl_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0] imm_q,      imm_d;
    logic [REGW-1:0]  rs1_q,      rs1_d;
    logic [REGW-1:0]  rs2_q,      rs2_d;
    logic [REGW-1:0]  rd_q,       rd_d;

    logic             lu_hit_s;
    logic [WIDTH-1:0] fwd_rs1_s;
    logic [WIDTH-1:0] fwd_rs2_s;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        lu_hit_s = 1'b0;
        if (valid_q && ctrl_q.mem_read && (rd_q != {REGW{1'b0}}) && id_valid &&
            ((id_rs1 == rd_q) || (id_rs2 == rd_q)) && !flush && !hold) begin
            lu_hit_s = 1'b1;
        end else begin
            lu_hit_s = 1'b0;
        end
    end

    // Next-state: hold freezes, flush/load-use insert a bubble, else capture
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (hold) begin
            valid_d = valid_q;
        end else if (flush || lu_hit_s) begin
            valid_d    = 1'b0;
            ctrl_d     = BUBBLE;
            pc_d       = {WIDTH{1'b0}};
            rs1_data_d = {WIDTH{1'b0}};
            rs2_data_d = {WIDTH{1'b0}};
            imm_d      = {WIDTH{1'b0}};
            rs1_d      = {REGW{1'b0}};
            rs2_d      = {REGW{1'b0}};
            rd_d       = {REGW{1'b0}};
        end else begin
            valid_d            = id_valid;
            ctrl_d.reg_write   = id_reg_write & id_valid;
            ctrl_d.mem_read    = id_mem_read & id_valid;
            ctrl_d.mem_write   = id_mem_write & id_valid;
            ctrl_d.src_a_pc    = id_src_a_pc;
            ctrl_d.src_b_imm   = id_src_b_imm;
            ctrl_d.alu_ctrl    = id_alu_ctrl;
            pc_d               = id_pc;
            rs1_data_d         = id_rs1_data;
            rs2_data_d         = id_rs2_data;
            imm_d              = id_imm;
            rs1_d              = id_rs1;
            rs2_d              = id_rs2;
            rd_d               = id_rd;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= BUBBLE;
            pc_q       <= {WIDTH{1'b0}};
            rs1_data_q <= {WIDTH{1'b0}};
            rs2_data_q <= {WIDTH{1'b0}};
            imm_q      <= {WIDTH{1'b0}};
            rs1_q      <= {REGW{1'b0}};
            rs2_q      <= {REGW{1'b0}};
            rd_q       <= {REGW{1'b0}};
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    fwd_unit #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rs1 (
        .rs            (rs1_q),
        .rs_data       (rs1_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_fwd_data  (mem_fwd_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs1_s)
    );

    fwd_unit #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rs2 (
        .rs            (rs2_q),
        .rs_data       (rs2_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_fwd_data  (mem_fwd_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2_s)
    );

    assign load_use_stall = lu_hit_s;
    assign ex_valid       = valid_q;
    assign alu_a          = ctrl_q.src_a_pc  ? pc_q  : fwd_rs1_s;
    assign alu_b          = ctrl_q.src_b_imm ? imm_q : fwd_rs2_s;
    assign alu_ctrl       = ctrl_q.alu_ctrl;
    assign ex_store_data  = fwd_rs2_s;
    assign ex_pc          = pc_q;
    assign ex_rd          = rd_q;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_fwd_data, wb_data;
    logic        load_use_stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t exp_q[$];

    id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (load_use_stall !== e.stall || ex_valid !== e.v || alu_a !== e.a ||
                alu_b !== e.b || alu_ctrl !== e.ctrl || ex_store_data !== e.sd ||
                ex_pc !== e.pc || ex_rd !== e.rd || ex_reg_write !== e.rw ||
                ex_mem_read !== e.mr || ex_mem_write !== e.mw) begin
                errors++;
                $display("FAIL %s: got stall=%b v=%b a=%h b=%h ctrl=%h sd=%h pc=%h rd=%0d rw=%b mr=%b mw=%b, expected stall=%b v=%b a=%h b=%h ctrl=%h sd=%h pc=%h rd=%0d rw=%b mr=%b mw=%b",
                         e.name, load_use_stall, ex_valid, alu_a, alu_b, alu_ctrl,
                         ex_store_data, ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                         e.stall, e.v, e.a, e.b, e.ctrl, e.sd, e.pc, e.rd, e.rw, e.mr, e.mw);
            end
        end
    end

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [31:0] rs1d, input logic [4:0] rs2,
                          input logic [31:0] rs2d, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [3:0] op,
                          input logic sa, input logic sb, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = rs1d;
        id_rs2 = rs2; id_rs2_data = rs2d; id_rd = rd; id_imm = imm;
        id_alu_ctrl = op; id_src_a_pc = sa; id_src_b_imm = sb;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        mem_reg_write = mwe; mem_rd = mrd; mem_fwd_data = md;
        wb_reg_write = wwe; wb_rd = wrd; wb_data = wd;
    endtask

    // Push the expectation for the current cycle, then advance one clock
    task automatic cyc(input string name, input logic stall, input logic v,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                       input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
        exp_t e;
        e.name = name; e.stall = stall; e.v = v; e.a = a; e.b = b; e.ctrl = ctrl;
        e.sd = sd; e.pc = pc; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'h40, 5'd1, 32'h7, 5'd2, 32'h8, 5'd3, 32'h4, ALU_SUB,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        cyc("reset_1", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("reset_2", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        set_id(1'b1, 32'h10, 5'd5, 32'h11, 5'd6, 32'h22, 5'd8, 32'h0, ALU_ADD,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("idle_after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        id_valid = 1'b0;
        hold = 1'b1;
        set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        cyc("fwd_mem_priority", 1'b0, 1'b1, 32'hAA, 32'h22, ALU_ADD, 32'h22, 32'h10, 5'd8, 1'b1, 1'b0, 1'b0);

        hold = 1'b0;
        mem_reg_write = 1'b0;
        set_id(1'b1, 32'h20, 5'd1, 32'h3, 5'd0, 32'h0, 5'd9, 32'h0, ALU_SUB,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("fwd_wb", 1'b0, 1'b1, 32'hBB, 32'h22, ALU_ADD, 32'h22, 32'h10, 5'd8, 1'b1, 1'b0, 1'b0);

        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h24, 5'd2, 32'h100, 5'd0, 32'h0, 5'd7, 32'h4, ALU_ADD,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("x0_guard", 1'b0, 1'b1, 32'h3, 32'h0, ALU_SUB, 32'h0, 32'h20, 5'd9, 1'b1, 1'b0, 1'b0);

        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h28, 5'd3, 32'h5, 5'd7, 32'h99, 5'd10, 32'h0, ALU_ADD,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("load_use_detect", 1'b1, 1'b1, 32'h100, 32'h4, ALU_ADD, 32'h0, 32'h24, 5'd7, 1'b1, 1'b1, 1'b0);

        set_fwd(1'b1, 5'd7, 32'h104, 1'b0, 5'd0, 32'h0);
        cyc("load_use_bubble", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
        flush = 1'b1;
        set_id(1'b1, 32'h2C, 5'd1, 32'h1, 5'd2, 32'h2, 5'd11, 32'h0, ALU_OR,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("load_use_resume", 1'b0, 1'b1, 32'h5, 32'h77, ALU_ADD, 32'h77, 32'h28, 5'd10, 1'b1, 1'b0, 1'b0);

        flush = 1'b0;
        wb_reg_write = 1'b0;
        set_id(1'b1, 32'h30, 5'd2, 32'h200, 5'd0, 32'h0, 5'd12, 32'h8, ALU_ADD,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("flush_bubble", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        flush = 1'b1;
        hold = 1'b1;
        set_id(1'b1, 32'h34, 5'd12, 32'h0, 5'd0, 32'h0, 5'd13, 32'h0, ALU_XOR,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("hold_flush_1", 1'b0, 1'b1, 32'h200, 32'h8, ALU_ADD, 32'h0, 32'h30, 5'd12, 1'b1, 1'b1, 1'b0);
        cyc("hold_flush_2", 1'b0, 1'b1, 32'h200, 32'h8, ALU_ADD, 32'h0, 32'h30, 5'd12, 1'b1, 1'b1, 1'b0);

        flush = 1'b0;
        hold = 1'b0;
        reset = 1'b1;
        cyc("load_use_rs1", 1'b1, 1'b1, 32'h200, 32'h8, ALU_ADD, 32'h0, 32'h30, 5'd12, 1'b1, 1'b1, 1'b0);

        reset = 1'b0;
        cyc("reset_mid_stall", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        set_id(1'b1, 32'h100, 5'd3, 32'h9, 5'd4, 32'h1, 5'd14, 32'hFFFFFFFC, ALU_ADD,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("post_reset_capture", 1'b0, 1'b1, 32'h0, 32'h0, ALU_XOR, 32'h0, 32'h34, 5'd13, 1'b1, 1'b0, 1'b0);

        hold = 1'b1;
        set_fwd(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0);
        cyc("pc_imm_select", 1'b0, 1'b1, 32'h100, 32'hFFFFFFFC, ALU_ADD, 32'h55, 32'h100, 5'd14, 1'b0, 1'b0, 1'b1);

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the ALU.
- Captures decoded operands and control from decode, forwards results from EX/MEM and MEM/WB, and presents final a, b and alu_ctrl to the ALU.
- Detects load-use hazards, inserts bubbles, and obeys hold/flush from hazard control.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  downstream stall; freeze stage.
- flush  in  1  taken branch/jump; kill the instruction entering EX.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  WIDTH  instruction PC.
- id_rs1_data, id_rs2_data  in  WIDTH  register-file read data.
- id_imm  in  WIDTH  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REGW  register indices.
- id_alu_ctrl  in  4  ALU op (0000 ADD … 1001 SRL).
- id_src_a_pc  in  1  operand a = PC.
- id_src_b_imm  in  1  operand b = imm.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- mem_rd  in  REGW  EX/MEM destination register.
- mem_reg_write  in  1  EX/MEM write enable.
- mem_fwd_data  in  WIDTH  EX/MEM ALU result.
- wb_rd  in  REGW  MEM/WB destination register.
- wb_reg_write  in  1  MEM/WB write enable.
- wb_data  in  WIDTH  writeback value.
- load_use_stall  out  1  request to freeze IF/ID this cycle.
- ex_valid  out  1  EX slot valid.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_ctrl  out  4  registered ALU op.
- ex_store_data  out  WIDTH  forwarded rs2 for stores.
- ex_pc  out  WIDTH  registered PC.
- ex_rd  out  REGW  registered destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid.

Behaviour:
- Register update priority each posedge:
  - reset: all fields 0, ex_valid=0.
  - else hold: all fields unchanged.
  - else flush: bubble.
  - else load_use_stall: bubble.
  - else capture id_* with ex_valid=id_valid.
- Bubble definition: ex_valid=0, reg_write/mem_read/mem_write=0, alu_ctrl=0000. Data fields are don't-care but cleared to 0.
- Reset output values: all outputs 0. alu_a/alu_b are 0 because registered data is 0.
- load_use_stall is combinational:
  - Asserted when ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
  - Forced 0 when flush=1 or hold=1.
- Forwarding is combinational on registered rs1/rs2, per operand:
  - If mem_reg_write & mem_rd≠0 & mem_rd==rsX, select mem_fwd_data.
  - Else if wb_reg_write & wb_rd≠0 & wb_rd==rsX, select wb_data.
  - Else select the registered rsX_data.
  - MEM takes priority over WB.
  - x0 is never forwarded.
- Operand mux:
  - alu_a = src_a_pc ? ex_pc : fwd_rs1.
  - alu_b = src_b_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always, independent of src_b_imm.
- Latency: one cycle from decode to ALU inputs. Forwarding adds zero cycles.
- hold together with flush: hold wins. The flush source keeps flush asserted until hold drops.
- Reset mid-stall: the next cycle is a bubble and load_use_stall deasserts.
- Register-file read-during-write is resolved inside the register file, not in this block.

Decomposition:
- Package riscv_pkg holds:
  - ALU_ADD…ALU_SRL 4-bit constants.
  - WIDTH/REGW defaults.
  - A packed ex_ctrl_t struct (reg_write, mem_read, mem_write, src_a_pc, src_b_imm, alu_ctrl).
  - A BUBBLE constant of type ex_ctrl_t.
- One sub-module, fwd_unit: combinational per-operand forwarding select, instantiated twice (rs1, rs2).

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1 → ex_valid=0, alu_a=alu_b=0, alu_ctrl=0000, load_use_stall=0.
- EX/MEM forward: EX holds rs1=5, reg x5 data 0x11, mem_rd=5/mem_reg_write=1/mem_fwd_data=0xAA, wb_rd=5/wb_data=0xBB → alu_a=0xAA (MEM priority). Drop mem_reg_write → alu_a=0xBB.
- x0 guard: rs2=0, mem_rd=0, mem_reg_write=1, mem_fwd_data=0xDEAD, rs2_data=0 → alu_b=0.
- Load-use: EX holds lw x7, ID holds add using rs2=7 → load_use_stall=1 same cycle. Next cycle ex_valid=0, ex_reg_write=0. Following cycle add captured, stall=0.
- Flush vs hold: flush=1 → next ex_valid=0. flush=1 with hold=1 → contents unchanged and load_use_stall=0.
- Immediate/PC select: id_pc=0x100, id_imm=0xFFFFFFFC, src_a_pc=1, src_b_imm=1, rs2 forwarded 0x55 → alu_a=0x100, alu_b=0xFFFFFFFC, ex_store_data=0x55.
